nf_reg_scan_tx: RTL and testbench

Consumer side of the CPU register scan port (reg_addr out, reg_data in). On a start request it walks register addresses 0..last_reg and drives reg_addr for each. It snapshots reg_data for each register and streams one ASCII line per register over a UART 8N1 transmitter. The block sits beside nf_cpu at top level, so the register file can be dumped to a host terminal without a debugger.

---
 rtl/nf_reg_scan_tx_if.sv | 30 +++
 rtl/nf_reg_scan_tx.sv | 154 +++++++++++++++
 tb/tb_nf_reg_scan_tx.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nf_reg_scan_tx_if.sv
// Control and scan-bus bundle between nf_reg_scan_tx and its neighbours.
// Handshake: start is a level request sampled only while the block is idle; busy rises
// the cycle after acceptance and falls together with the single-cycle done pulse.
// reg_data is a combinational function of reg_addr.
interface nf_reg_scan_tx_if;
  logic        start;
  logic        busy;
  logic        done;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data;
  logic [2:0]  dbg_state;

  modport master (
    output start,
    output reg_data,
    input  busy,
    input  done,
    input  reg_addr,
    input  dbg_state
  );

  modport slave (
    input  start,
    input  reg_data,
    output busy,
    output done,
    output reg_addr,
    output dbg_state
  );
endinterface

// File: rtl/nf_reg_scan_tx.sv
// Walks CPU scan registers 0..last_reg and prints each as "AA:DDDDDDDD\r\n"
// over a UART 8N1 transmitter.
module nf_reg_scan_tx #(
  parameter int baud_div = 434,
  parameter int last_reg = 31
) (
  input  logic            clk,
  input  logic            resetn,
  nf_reg_scan_tx_if.slave bus,
  output logic            tx
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    SEND      = 3'd2,
    NEXT_CHAR = 3'd3,
    NEXT_REG  = 3'd4,
    DONE      = 3'd5
  } state_t;

  localparam int             BW        = $clog2(baud_div);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(baud_div - 1);
  localparam logic [4:0]     ADDR_LAST = 5'(last_reg);

  state_t         state;
  logic [4:0]     reg_addr;
  logic [31:0]    snapshot;
  logic [3:0]     char_idx;
  logic [BW-1:0]  baud_cnt;
  logic [3:0]     bit_cnt;
  logic [9:0]     tx_shift;
  logic           busy;
  logic           done;
  logic [7:0]     next_char;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'd0, n};
    else           return 8'h37 + {4'd0, n};
  endfunction

  function automatic logic [7:0] line_char(input logic [3:0]  idx,
                                           input logic [4:0]  addr,
                                           input logic [31:0] data);
    case (idx)
      4'd0:    return hex_char({3'b000, addr[4]});
      4'd1:    return hex_char(addr[3:0]);
      4'd2:    return 8'h3A;
      4'd3:    return hex_char(data[31:28]);
      4'd4:    return hex_char(data[27:24]);
      4'd5:    return hex_char(data[23:20]);
      4'd6:    return hex_char(data[19:16]);
      4'd7:    return hex_char(data[15:12]);
      4'd8:    return hex_char(data[11:8]);
      4'd9:    return hex_char(data[7:4]);
      4'd10:   return hex_char(data[3:0]);
      4'd11:   return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  assign next_char = line_char(char_idx + 4'd1, reg_addr, snapshot);

  // tx is registered from tx_shift[0], so it trails the SEND state by one cycle.
  // NEXT_CHAR drives the first start-bit cycle itself to keep characters gapless.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      reg_addr <= '0;
      snapshot <= '0;
      char_idx <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.start) begin
            state    <= LOAD;
            reg_addr <= '0;
            busy     <= 1'b1;
          end
        end

        LOAD: begin
          snapshot <= bus.reg_data;
          char_idx <= '0;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          tx_shift <= {1'b1, line_char(4'd0, reg_addr, bus.reg_data), 1'b0};
          state    <= SEND;
        end

        SEND: begin
          tx <= tx_shift[0];
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_cnt == 4'd9) begin
              state <= NEXT_CHAR;
            end else begin
              bit_cnt  <= bit_cnt + 4'd1;
              tx_shift <= {1'b1, tx_shift[9:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end

        NEXT_CHAR: begin
          if (char_idx != 4'd12) begin
            char_idx <= char_idx + 4'd1;
            tx_shift <= {1'b1, next_char, 1'b0};
            bit_cnt  <= '0;
            baud_cnt <= BW'(1);
            tx       <= 1'b0;
            state    <= SEND;
          end else begin
            state <= NEXT_REG;
          end
        end

        NEXT_REG: begin
          if (reg_addr == ADDR_LAST) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            reg_addr <= reg_addr + 5'd1;
            state    <= LOAD;
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.reg_addr  = reg_addr;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_nf_reg_scan_tx.sv
// Directed bench for nf_reg_scan_tx: three instances cover single line, full dump
// and reset-abort; a UART decoder feeds a byte scoreboard.
module tb_nf_reg_scan_tx;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn;
  logic resetn_c;
  always #5 clk = ~clk;

  logic        tx_a, tx_b, tx_c;
  logic [31:0] data_a;

  nf_reg_scan_tx_if if_a ();
  nf_reg_scan_tx_if if_b ();
  nf_reg_scan_tx_if if_c ();

  assign if_a.reg_data = data_a;
  assign if_b.reg_data = {3'b000, if_b.reg_addr} * 32'h0101_0101;
  assign if_c.reg_data = {3'b000, if_c.reg_addr} * 32'h0101_0101;

  nf_reg_scan_tx #(.baud_div(4), .last_reg(0)) u_a (
    .clk(clk), .resetn(resetn), .bus(if_a.slave), .tx(tx_a));
  nf_reg_scan_tx #(.baud_div(4), .last_reg(31)) u_b (
    .clk(clk), .resetn(resetn), .bus(if_b.slave), .tx(tx_b));
  nf_reg_scan_tx #(.baud_div(8), .last_reg(1)) u_c (
    .clk(clk), .resetn(resetn_c), .bus(if_c.slave), .tx(tx_c));

  // ---------------- monitor selection ----------------
  int          mon_sel;
  logic        mon_tx, mon_busy, mon_done;
  logic [4:0]  mon_addr;

  always_comb begin
    mon_tx   = tx_a;
    mon_busy = if_a.busy;
    mon_done = if_a.done;
    mon_addr = if_a.reg_addr;
    case (mon_sel)
      1: begin
        mon_tx = tx_b; mon_busy = if_b.busy; mon_done = if_b.done; mon_addr = if_b.reg_addr;
      end
      2: begin
        mon_tx = tx_c; mon_busy = if_c.busy; mon_done = if_c.done; mon_addr = if_c.reg_addr;
      end
      default: ;
    endcase
  end

  int done_cnt [3];
  always @(negedge clk) begin
    if (if_a.done === 1'b1) done_cnt[0]++;
    if (if_b.done === 1'b1) done_cnt[1]++;
    if (if_c.done === 1'b1) done_cnt[2]++;
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    logic [7:0] r;
    r = (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h41 + {4'd0, n} - 8'd10);
    return r;
  endfunction

  task automatic push_line(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back(hex_ascii({3'b000, a[4]}));
    exp_q.push_back(hex_ascii(a[3:0]));
    exp_q.push_back(8'h3A);
    for (int i = 7; i >= 0; i--) exp_q.push_back(hex_ascii(d[i*4 +: 4]));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // ---------------- driver / decoder tasks ----------------
  task automatic pulse_start(input int sel);
    case (sel)
      0: if_a.start = 1'b1;
      1: if_b.start = 1'b1;
      default: if_c.start = 1'b1;
    endcase
    @(negedge clk);
    case (sel)
      0: if_a.start = 1'b0;
      1: if_b.start = 1'b0;
      default: if_c.start = 1'b0;
    endcase
  endtask

  // Called on a negedge; returns on the last negedge of the stop bit.
  task automatic recv_char(input int bd, input int timeout, output logic [7:0] ch,
                           output bit ok, output int waited);
    logic [9:0] bits;
    bit glitch;
    waited = 0; ok = 1'b0; ch = '0; bits = '0; glitch = 1'b0;
    while (mon_tx !== 1'b0 && waited < timeout) begin
      @(negedge clk);
      waited++;
    end
    if (mon_tx !== 1'b0) return;
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < bd; k++) begin
        if (b != 0 || k != 0) @(negedge clk);
        if (k == 0) bits[b] = mon_tx;
        else if (mon_tx !== bits[b]) glitch = 1'b1;
      end
    end
    ch = bits[8:1];
    ok = (bits[0] == 1'b0) && (bits[9] == 1'b1) && !glitch;
  endtask

  task automatic recv_line(input int bd, input int first_timeout, input logic [4:0] exp_addr,
                           output int first_wait);
    logic [7:0] ch, exp;
    bit ok;
    int w;
    first_wait = -1;
    for (int i = 0; i < 13; i++) begin
      recv_char(bd, (i == 0) ? first_timeout : 1, ch, ok, w);
      if (i == 0) begin
        first_wait = w;
        check_eq("line_addr", {27'd0, mon_addr}, {27'd0, exp_addr});
      end
      check_eq("frame_ok", {31'd0, ok}, 32'd1);
      if (!ok) begin
        exp_q.delete();
        return;
      end
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      check_eq("char", {24'd0, ch}, {24'd0, exp});
    end
  endtask

  task automatic wait_done(input int limit, input int exp_cnt);
    int n = 0;
    while (mon_done !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check_eq("done_seen", {31'd0, mon_done}, 32'd1);
    check_eq("busy_at_done", {31'd0, mon_busy}, 32'd0);
    @(negedge clk);
    check_eq("done_width", {31'd0, mon_done}, 32'd0);
    check_eq("done_count", done_cnt[mon_sel], exp_cnt);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int fw;
    logic [7:0] ch, exp;
    bit ok;
    int w;

    mon_sel = 0;
    data_a = 32'h0;
    resetn = 1'b0;
    resetn_c = 1'b0;
    if_a.start = 1'b1;
    if_b.start = 1'b1;
    if_c.start = 1'b1;

    // Reset held with start asserted: outputs stay at reset values.
    repeat (6) begin
      @(negedge clk);
      check_eq("rst_tx_a",   {31'd0, tx_a}, 32'd1);
      check_eq("rst_busy_a", {31'd0, if_a.busy}, 32'd0);
      check_eq("rst_done_a", {31'd0, if_a.done}, 32'd0);
      check_eq("rst_addr_b", {27'd0, if_b.reg_addr}, 32'd0);
      check_eq("rst_tx_b",   {31'd0, tx_b}, 32'd1);
      check_eq("rst_busy_b", {31'd0, if_b.busy}, 32'd0);
    end
    check_eq("rst_state_a", {29'd0, if_a.dbg_state}, 32'd0);
    if_a.start = 1'b0;
    if_b.start = 1'b0;
    if_c.start = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    resetn_c = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check_eq("idle_tx_a", {31'd0, tx_a}, 32'd1);
      check_eq("idle_tx_c", {31'd0, tx_c}, 32'd1);
      check_eq("idle_busy_b", {31'd0, if_b.busy}, 32'd0);
    end

    // Single line DEADBEEF, with a stray start pulse mid-line.
    mon_sel = 0;
    data_a = 32'hDEAD_BEEF;
    push_line(5'd0, 32'hDEAD_BEEF);
    pulse_start(0);
    check_eq("busy_after_start_a", {31'd0, mon_busy}, 32'd1);
    fork
      begin
        repeat (100) @(negedge clk);
        if_a.start = 1'b1;
        @(negedge clk);
        if_a.start = 1'b0;
      end
    join_none
    recv_line(4, 2, 5'd0, fw);
    check_eq("latency_a", fw, 2);
    wait_done(20, 1);
    repeat (6) @(negedge clk);
    check_eq("no_restart_busy_a", {31'd0, if_a.busy}, 32'd0);
    check_eq("no_restart_tx_a", {31'd0, tx_a}, 32'd1);

    // Snapshot hold: reg_data changes during the third character.
    data_a = 32'h1234_5678;
    push_line(5'd0, 32'h1234_5678);
    pulse_start(0);
    fork
      begin
        repeat (95) @(negedge clk);
        data_a = 32'hFFFF_FFFF;
      end
    join_none
    recv_line(4, 2, 5'd0, fw);
    wait_done(20, 2);

    // Reset during data bit 3 of character 5 (baud_div 8).
    mon_sel = 2;
    push_line(5'd0, 32'h0);
    pulse_start(2);
    for (int i = 0; i < 5; i++) begin
      recv_char(8, (i == 0) ? 2 : 1, ch, ok, w);
      check_eq("c_frame_ok", {31'd0, ok}, 32'd1);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      check_eq("c_char", {24'd0, ch}, {24'd0, exp});
    end
    exp_q.delete();
    @(negedge clk);
    check_eq("c5_start_bit", {31'd0, tx_c}, 32'd0);
    repeat (35) @(negedge clk);
    check_eq("c5_data_bit3", {31'd0, tx_c}, 32'd0);
    check_eq("c5_busy", {31'd0, if_c.busy}, 32'd1);
    #2 resetn_c = 1'b0;
    #1;
    check_eq("abort_tx", {31'd0, tx_c}, 32'd1);
    check_eq("abort_busy", {31'd0, if_c.busy}, 32'd0);
    check_eq("abort_addr", {27'd0, if_c.reg_addr}, 32'd0);
    check_eq("abort_done", {31'd0, if_c.done}, 32'd0);
    check_eq("abort_state", {29'd0, if_c.dbg_state}, 32'd0);
    repeat (2) @(negedge clk);
    check_eq("abort_tx_hold", {31'd0, tx_c}, 32'd1);
    resetn_c = 1'b1;
    repeat (3) @(negedge clk);
    push_line(5'd0, 32'h0000_0000);
    push_line(5'd1, 32'h0101_0101);
    pulse_start(2);
    recv_line(8, 2, 5'd0, fw);
    check_eq("latency_c", fw, 2);
    recv_line(8, 10, 5'd1, fw);
    wait_done(20, 1);

    // Full dump with start held high: a second dump follows done.
    mon_sel = 1;
    if_b.start = 1'b1;
    @(negedge clk);
    check_eq("busy_after_start_b", {31'd0, mon_busy}, 32'd1);
    for (int l = 0; l < 32; l++) begin
      push_line(5'(l), l * 32'h0101_0101);
      recv_line(4, (l == 0) ? 2 : 10, 5'(l), fw);
      if (l == 0) check_eq("latency_b", fw, 2);
    end
    wait_done(20, 1);
    @(negedge clk);
    check_eq("redump_busy", {31'd0, if_b.busy}, 32'd1);
    check_eq("redump_addr", {27'd0, if_b.reg_addr}, 32'd0);
    if_b.start = 1'b0;
    for (int l = 0; l < 32; l++) begin
      push_line(5'(l), l * 32'h0101_0101);
      recv_line(4, (l == 0) ? 2 : 10, 5'(l), fw);
      if (l == 0) check_eq("latency_b2", fw, 2);
    end
    wait_done(20, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
